stack_sequencer: RTL and testbench
==================================

# stack_sequencer

Multi-byte push/pull sequencer for the 6502 hardware stack. It owns the stack pointer S and drives page-1 memory cycles over a request/acknowledge memory port. The instruction sequencer issues a single command for PHA/PHP (1 byte), JSR (2 bytes) or BRK/IRQ (3 bytes), and the block walks S, addresses and data through each byte. It is the bus-master counterpart to the stack-pointer and datapath registers: they are loaded from and drive the internal buses, and this block sources and sinks the stack traffic on the external memory side.

## Interface
- STACK_PAGE, 8'h01, high address byte of every stack access
- RESET_SP, 8'hFD, value of S after reset
- CLK  in  1  system clock, all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- PUSH_START  in  1  start a push of COUNT bytes; sampled only in IDLE
- PULL_START  in  1  start a pull of COUNT bytes; sampled only in IDLE
- COUNT  in  2  byte count 1..3; 0 makes the start ignored
- PUSH_DATA  in  24  byte k at [8k+7:8k]; byte 0 is pushed first; sampled at start
- SP_LOAD  in  1  load S from SP_DATA (TXS); honoured only in IDLE
- SP_DATA  in  8  new S value
- SP_OUT  out  8  current S
- PULL_DATA  out  24  byte k pulled lands at [8k+7:8k]
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- MEM_REQ  out  1  memory request
- MEM_WE  out  1  1 = write (push), 0 = read (pull); valid while MEM_REQ is high
- MEM_ADDR  out  16  stack address
- MEM_WDATA  out  8  write data
- MEM_RDATA  in  8  read data, valid in the cycle MEM_ACK is high
- MEM_ACK  in  1  completes the current request in the cycle it is high

## Operation
- States: IDLE, PUSH, PULL, FIN.
- IDLE: priority is SP_LOAD > PUSH_START > PULL_START.
  - SP_LOAD: S <= SP_DATA. Any start in the same cycle is dropped.
  - Accepted start: latch PUSH_DATA and COUNT, clear a byte index to 0, then go to PUSH or PULL. An accepted pull also clears PULL_DATA to 0.
  - A start with COUNT == 0 is ignored and the block stays in IDLE.
- PUSH: MEM_REQ=1, MEM_WE=1, MEM_ADDR={STACK_PAGE,S}, MEM_WDATA=latched byte[index].
  - On MEM_ACK: S <= S-1 and index++. After the last byte, go to FIN.
- PULL: MEM_REQ=1, MEM_WE=0, MEM_ADDR={STACK_PAGE,S+1} (8-bit add).
  - On MEM_ACK: S <= S+1 and PULL_DATA byte[index] <= MEM_RDATA, then index++. After the last byte, go to FIN.
- FIN: DONE=1, BUSY=1, MEM_REQ=0. Always returns to IDLE on the next cycle.
- S arithmetic is modulo 256. It wraps 8'h00 -> 8'hFF on push and 8'hFF -> 8'h00 on pull; the address never leaves STACK_PAGE.
- Without MEM_ACK, MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA hold stable indefinitely. MEM_ACK is ignored while MEM_REQ=0.
- Starts and SP_LOAD arriving while BUSY are ignored, not queued.
- Outside PUSH/PULL: MEM_ADDR=0 and MEM_WDATA=0. PULL_DATA holds its value until the next accepted pull.

## Timing
- Reset values: S=RESET_SP, SP_OUT=RESET_SP, state IDLE, BUSY=0, DONE=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, PULL_DATA=0.
- RESET mid-operation aborts the command. MEM_REQ is low from the edge RESET is sampled on, and no partial S update occurs at that edge.
- Start sampled at edge t: MEM_REQ is high from cycle t+1.
- Each byte occupies one REQ cycle plus its wait cycles. With MEM_ACK tied high, an n-byte command has REQ high for cycles t+1..t+n, DONE in cycle t+n+1, and IDLE in cycle t+n+2.
- MEM_REQ is never deasserted between the bytes of one command.
- SP_OUT reflects each S update in the cycle after the acknowledging edge.
- The earliest next start is the cycle after DONE.

## Test plan
- Reset, then push of 1 byte with PUSH_DATA=24'h0000A5 and ACK tied high -> write 8'hA5 to 16'h01FD, S=8'hFC, DONE in cycle 3.
- SP_LOAD 8'hFF, push of 3 bytes with data 24'h33_22_11 -> writes 11@01FF, 22@01FE, 33@01FD, back to back; final S=8'hFC.
- S=8'hFC, pull of 2 bytes with memory 01FD=8'h34, 01FE=8'h12 -> PULL_DATA=24'h001234, S=8'hFE.
- Wrap: S=8'h00 push 1 -> address 16'h0100, S=8'hFF; then pull 1 -> address 16'h0100, S=8'h00.
- Hold ACK low for 4 cycles during byte 1 of a 2-byte push -> MEM_ADDR and MEM_WDATA stable, S unchanged until ACK. PUSH_START/SP_LOAD pulsed while BUSY -> no effect.
- RESET asserted during byte 2 of a 3-byte pull -> MEM_REQ low next cycle, S=8'hFD, BUSY=0. PUSH_START and PULL_START together in IDLE -> push executes.

Source files
------------

// File: rtl/stack_mem_if.sv
// Request/acknowledge memory port used for 6502 page-1 stack traffic.
// The sequencer is the master; memory (or a bus bridge) is the slave.
interface stack_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/stack_sequencer.sv
// Multi-byte push/pull sequencer for the 6502 hardware stack: owns S and walks
// 1..3 byte PHA/PHP, JSR and BRK/IRQ stack transfers over a req/ack memory port.
module stack_sequencer #(
    parameter logic [7:0] STACK_PAGE = 8'h01,
    parameter logic [7:0] RESET_SP   = 8'hFD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_start,
    input  logic               pull_start,
    input  logic [1:0]         count,
    input  logic [23:0]        push_data,
    input  logic               sp_load,
    input  logic [7:0]         sp_data,
    output logic [7:0]         sp_out,
    output logic [23:0]        pull_data,
    output logic               busy,
    output logic               done,
    stack_mem_if.master        mem
);

    typedef enum logic [1:0] {IDLE, PUSH, PULL, FIN} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  sp_reg, sp_next;
    logic [23:0] data_reg, data_next;
    logic [1:0]  count_reg, count_next;
    logic [1:0]  index_reg, index_next;
    logic [23:0] pull_data_reg;
    logic        pull_clear;
    logic        pull_we;

    logic [7:0]  push_bytes [0:2];
    logic [7:0]  cur_byte;
    logic [7:0]  sp_inc;
    logic [7:0]  sp_dec;
    logic        last_byte;

    logic        mem_req_c;
    logic        mem_we_c;
    logic [15:0] mem_addr_c;
    logic [7:0]  mem_wdata_c;

    assign sp_inc    = sp_reg + 8'd1;
    assign sp_dec    = sp_reg - 8'd1;
    assign last_byte = (index_reg == (count_reg - 2'd1));

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            assign push_bytes[gi] = data_reg[8*gi +: 8];

            // Each pulled byte lands in its own lane; an accepted pull wipes all lanes.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pull_data_reg[8*gi +: 8] <= 8'h00;
                end else if (pull_clear) begin
                    pull_data_reg[8*gi +: 8] <= 8'h00;
                end else if (pull_we && (index_reg == 2'(gi))) begin
                    pull_data_reg[8*gi +: 8] <= mem.mem_rdata;
                end
            end
        end
    endgenerate

    always_comb begin
        case (index_reg)
            2'd0:    cur_byte = push_bytes[0];
            2'd1:    cur_byte = push_bytes[1];
            default: cur_byte = push_bytes[2];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            sp_reg    <= RESET_SP;
            data_reg  <= 24'h0;
            count_reg <= 2'd0;
            index_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            sp_reg    <= sp_next;
            data_reg  <= data_next;
            count_reg <= count_next;
            index_reg <= index_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sp_next     = sp_reg;
        data_next   = data_reg;
        count_next  = count_reg;
        index_next  = index_reg;
        pull_clear  = 1'b0;
        pull_we     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = 16'h0000;
        mem_wdata_c = 8'h00;

        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                // SP load wins and swallows any start presented alongside it.
                if (sp_load) begin
                    sp_next = sp_data;
                end else if (push_start && (count != 2'd0)) begin
                    data_next  = push_data;
                    count_next = count;
                    index_next = 2'd0;
                    state_next = PUSH;
                end else if (pull_start && (count != 2'd0)) begin
                    data_next  = push_data;
                    count_next = count;
                    index_next = 2'd0;
                    pull_clear = 1'b1;
                    state_next = PULL;
                end
            end
            PUSH: begin
                mem_req_c   = 1'b1;
                mem_we_c    = 1'b1;
                mem_addr_c  = {STACK_PAGE, sp_reg};
                mem_wdata_c = cur_byte;
                if (mem.mem_ack) begin
                    sp_next    = sp_dec;
                    index_next = index_reg + 2'd1;
                    if (last_byte) state_next = FIN;
                end
            end
            PULL: begin
                // The 6502 stack is empty-descending, so a pull reads S+1.
                mem_req_c  = 1'b1;
                mem_addr_c = {STACK_PAGE, sp_inc};
                if (mem.mem_ack) begin
                    sp_next    = sp_inc;
                    pull_we    = 1'b1;
                    index_next = index_reg + 2'd1;
                    if (last_byte) state_next = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem.mem_req   = mem_req_c;
    assign mem.mem_we    = mem_we_c;
    assign mem.mem_addr  = mem_addr_c;
    assign mem.mem_wdata = mem_wdata_c;
    assign sp_out        = sp_reg;
    assign pull_data     = pull_data_reg;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: page-1 memory model with controllable
// acknowledge, one log line per completed memory transaction.
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push_start = 1'b0;
    logic        pull_start = 1'b0;
    logic [1:0]  count = 2'd0;
    logic [23:0] push_data = 24'h0;
    logic        sp_load = 1'b0;
    logic [7:0]  sp_data = 8'h00;
    logic [7:0]  sp_out;
    logic [23:0] pull_data;
    logic        busy;
    logic        done;

    logic        ack_en = 1'b1;
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = 8'h00;
    logic [7:0]  pre_data = 8'h00;
    logic [7:0]  mem_model [0:255];

    logic [15:0] log_addr [0:63];
    logic [7:0]  log_data [0:63];
    logic        log_we   [0:63];
    int          log_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;

    stack_mem_if mem_if ();

    stack_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .push_start (push_start),
        .pull_start (pull_start),
        .count      (count),
        .push_data  (push_data),
        .sp_load    (sp_load),
        .sp_data    (sp_data),
        .sp_out     (sp_out),
        .pull_data  (pull_data),
        .busy       (busy),
        .done       (done),
        .mem        (mem_if.master)
    );

    always #5 clk = ~clk;

    assign mem_if.mem_ack   = ack_en;
    assign mem_if.mem_rdata = mem_model[mem_if.mem_addr[7:0]];

    always @(posedge clk) begin
        if (pre_en) mem_model[pre_addr] <= pre_data;
        if (mem_if.mem_req && mem_if.mem_ack) begin
            if (mem_if.mem_we) mem_model[mem_if.mem_addr[7:0]] <= mem_if.mem_wdata;
            log_addr[log_cnt[5:0]] <= mem_if.mem_addr;
            log_data[log_cnt[5:0]] <= mem_if.mem_we ? mem_if.mem_wdata : mem_if.mem_rdata;
            log_we[log_cnt[5:0]]   <= mem_if.mem_we;
            log_cnt <= log_cnt + 1;
            $display("%0t txn %s addr=%04h data=%02h sp=%02h", $time,
                     mem_if.mem_we ? "WR" : "RD", mem_if.mem_addr,
                     mem_if.mem_we ? mem_if.mem_wdata : mem_if.mem_rdata, sp_out);
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic load_sp(input logic [7:0] v);
        @(negedge clk);
        sp_load = 1'b1; sp_data = v;
        @(negedge clk);
        sp_load = 1'b0;
    endtask

    // Starts a command and returns at the negedge where done is seen (or the bound expires).
    task automatic run_cmd(input logic is_push, input logic is_pull, input logic [1:0] cnt,
                           input logic [23:0] data, output int done_cyc, output int req_cyc,
                           output logic timed_out);
        @(negedge clk);
        push_start = is_push; pull_start = is_pull; count = cnt; push_data = data;
        @(negedge clk);
        push_start = 1'b0; pull_start = 1'b0;
        done_cyc = 1; req_cyc = 0; timed_out = 1'b0;
        while (done !== 1'b1) begin
            if (mem_if.mem_req === 1'b1) req_cyc++;
            if (done_cyc >= 40) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            done_cyc++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (sp_out !== 8'hFD) begin n_fail++; $display("FAIL reset_sp got=%h exp=fd", sp_out); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        n_checks++; if (mem_if.mem_req !== 1'b0 || mem_if.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_req_we got=%b%b exp=00", mem_if.mem_req, mem_if.mem_we); end
        n_checks++; if (mem_if.mem_addr !== 16'h0 || mem_if.mem_wdata !== 8'h0) begin n_fail++; $display("FAIL reset_addr_wdata got=%h/%h exp=0000/00", mem_if.mem_addr, mem_if.mem_wdata); end
        n_checks++; if (pull_data !== 24'h0) begin n_fail++; $display("FAIL reset_pull_data got=%h exp=000000", pull_data); end
        reset = 1'b0;
    endtask

    task automatic test_push_one();
        int base, dc, rc; logic to;
        base = log_cnt;
        run_cmd(1'b1, 1'b0, 2'd1, 24'h0000A5, dc, rc, to);
        n_checks++; if (to !== 1'b0 || dc != 2 || rc != 1) begin n_fail++; $display("FAIL push1_timing got done_cyc=%0d req=%0d to=%b exp 2/1/0", dc, rc, to); end
        n_checks++; if (log_cnt != base + 1 || log_addr[base] !== 16'h01FD || log_data[base] !== 8'hA5 || log_we[base] !== 1'b1)
            begin n_fail++; $display("FAIL push1_write got n=%0d addr=%h data=%h we=%b exp 1 01fd a5 1", log_cnt - base, log_addr[base], log_data[base], log_we[base]); end
        n_checks++; if (sp_out !== 8'hFC || busy !== 1'b1 || mem_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL push1_fin got sp=%h busy=%b req=%b exp fc 1 0", sp_out, busy, mem_if.mem_req); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || mem_if.mem_addr !== 16'h0) begin n_fail++; $display("FAIL push1_idle got busy=%b done=%b addr=%h exp 0 0 0000", busy, done, mem_if.mem_addr); end
    endtask

    task automatic test_back_to_back();
        int base, dc, rc; logic to;
        load_sp(8'hFF);
        n_checks++; if (sp_out !== 8'hFF) begin n_fail++; $display("FAIL sp_load got=%h exp=ff", sp_out); end
        base = log_cnt;
        run_cmd(1'b1, 1'b0, 2'd3, 24'h332211, dc, rc, to);
        n_checks++; if (to !== 1'b0 || dc != 4 || rc != 3) begin n_fail++; $display("FAIL push3_timing got done_cyc=%0d req=%0d to=%b exp 4/3/0", dc, rc, to); end
        n_checks++; if (log_cnt != base + 3 || log_addr[base] !== 16'h01FF || log_data[base] !== 8'h11 || log_addr[base+1] !== 16'h01FE
                        || log_data[base+1] !== 8'h22 || log_addr[base+2] !== 16'h01FD || log_data[base+2] !== 8'h33)
            begin n_fail++; $display("FAIL push3_writes got n=%0d %h:%h %h:%h %h:%h exp 3 01ff:11 01fe:22 01fd:33", log_cnt - base,
                                     log_addr[base], log_data[base], log_addr[base+1], log_data[base+1], log_addr[base+2], log_data[base+2]); end
        n_checks++; if (sp_out !== 8'hFC) begin n_fail++; $display("FAIL push3_sp got=%h exp=fc", sp_out); end
        @(negedge clk);
    endtask

    task automatic test_pull_two();
        int base, dc, rc; logic to;
        preload(8'hFD, 8'h34);
        preload(8'hFE, 8'h12);
        base = log_cnt;
        run_cmd(1'b0, 1'b1, 2'd2, 24'hFFFFFF, dc, rc, to);
        n_checks++; if (to !== 1'b0 || dc != 3 || rc != 2) begin n_fail++; $display("FAIL pull2_timing got done_cyc=%0d req=%0d to=%b exp 3/2/0", dc, rc, to); end
        n_checks++; if (log_cnt != base + 2 || log_addr[base] !== 16'h01FD || log_addr[base+1] !== 16'h01FE || log_we[base] !== 1'b0 || log_we[base+1] !== 1'b0)
            begin n_fail++; $display("FAIL pull2_reads got n=%0d %h(we%b) %h(we%b) exp 2 01fd(we0) 01fe(we0)", log_cnt - base, log_addr[base], log_we[base], log_addr[base+1], log_we[base+1]); end
        n_checks++; if (pull_data !== 24'h001234 || sp_out !== 8'hFE) begin n_fail++; $display("FAIL pull2_result got data=%h sp=%h exp 001234 fe", pull_data, sp_out); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int base, dc, rc; logic to;
        load_sp(8'h00);
        base = log_cnt;
        run_cmd(1'b1, 1'b0, 2'd1, 24'h00005A, dc, rc, to);
        n_checks++; if (to !== 1'b0 || log_addr[base] !== 16'h0100 || log_we[base] !== 1'b1 || sp_out !== 8'hFF)
            begin n_fail++; $display("FAIL wrap_push got addr=%h we=%b sp=%h to=%b exp 0100 1 ff 0", log_addr[base], log_we[base], sp_out, to); end
        @(negedge clk);
        base = log_cnt;
        run_cmd(1'b0, 1'b1, 2'd1, 24'h0, dc, rc, to);
        n_checks++; if (to !== 1'b0 || log_addr[base] !== 16'h0100 || log_we[base] !== 1'b0 || sp_out !== 8'h00)
            begin n_fail++; $display("FAIL wrap_pull got addr=%h we=%b sp=%h to=%b exp 0100 0 00 0", log_addr[base], log_we[base], sp_out, to); end
        n_checks++; if (pull_data !== 24'h00005A) begin n_fail++; $display("FAIL wrap_pull_data got=%h exp=00005a", pull_data); end
        @(negedge clk);
    endtask

    task automatic test_count_zero();
        @(negedge clk);
        push_start = 1'b1; count = 2'd0;
        @(negedge clk);
        push_start = 1'b0;
        n_checks++; if (busy !== 1'b0 || mem_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL count_zero got busy=%b req=%b exp 0 0", busy, mem_if.mem_req); end
    endtask

    task automatic test_wait_states();
        int base;
        load_sp(8'h80);
        base = log_cnt;
        ack_en = 1'b0;
        @(negedge clk);
        push_start = 1'b1; count = 2'd2; push_data = 24'h00BBAA;
        @(negedge clk);
        push_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 16'h0180 || mem_if.mem_wdata !== 8'hAA || sp_out !== 8'h80)
                begin n_fail++; $display("FAIL wait_hold[%0d] got req=%b addr=%h wdata=%h sp=%h exp 1 0180 aa 80", i, mem_if.mem_req, mem_if.mem_addr, mem_if.mem_wdata, sp_out); end
            push_start = 1'b1; sp_load = 1'b1; sp_data = 8'h11; count = 2'd3;
            @(negedge clk);
        end
        push_start = 1'b0; sp_load = 1'b0; ack_en = 1'b1;
        n_checks++; if (mem_if.mem_addr !== 16'h0180 || sp_out !== 8'h80) begin n_fail++; $display("FAIL wait_busy_ignore got addr=%h sp=%h exp 0180 80", mem_if.mem_addr, sp_out); end
        @(negedge clk);
        n_checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 16'h017F || mem_if.mem_wdata !== 8'hBB || sp_out !== 8'h7F)
            begin n_fail++; $display("FAIL wait_byte1 got req=%b addr=%h wdata=%h sp=%h exp 1 017f bb 7f", mem_if.mem_req, mem_if.mem_addr, mem_if.mem_wdata, sp_out); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || sp_out !== 8'h7E) begin n_fail++; $display("FAIL wait_done got done=%b sp=%h exp 1 7e", done, sp_out); end
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || log_cnt != base + 2 || sp_out !== 8'h7E) begin n_fail++; $display("FAIL wait_no_queue got busy=%b n=%0d sp=%h exp 0 2 7e", busy, log_cnt - base, sp_out); end
    endtask

    task automatic test_reset_abort();
        int base, dc, rc; logic to;
        load_sp(8'hFA);
        preload(8'hFB, 8'hC1);
        @(negedge clk);
        pull_start = 1'b1; count = 2'd3;
        @(negedge clk);
        pull_start = 1'b0;
        n_checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b0 || mem_if.mem_addr !== 16'h01FB) begin n_fail++; $display("FAIL abort_byte0 got req=%b we=%b addr=%h exp 1 0 01fb", mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr); end
        @(negedge clk);
        n_checks++; if (mem_if.mem_addr !== 16'h01FC || sp_out !== 8'hFB) begin n_fail++; $display("FAIL abort_byte1 got addr=%h sp=%h exp 01fc fb", mem_if.mem_addr, sp_out); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_if.mem_req !== 1'b0 || sp_out !== 8'hFD || busy !== 1'b0 || pull_data !== 24'h0)
            begin n_fail++; $display("FAIL abort_reset got req=%b sp=%h busy=%b pdata=%h exp 0 fd 0 000000", mem_if.mem_req, sp_out, busy, pull_data); end
        reset = 1'b0;
        base = log_cnt;
        run_cmd(1'b1, 1'b1, 2'd1, 24'h000077, dc, rc, to);
        n_checks++; if (to !== 1'b0 || dc != 2 || log_cnt != base + 1 || log_we[base] !== 1'b1 || log_addr[base] !== 16'h01FD || log_data[base] !== 8'h77)
            begin n_fail++; $display("FAIL both_starts got n=%0d we=%b addr=%h data=%h dc=%0d exp 1 1 01fd 77 2", log_cnt - base, log_we[base], log_addr[base], log_data[base], dc); end
        n_checks++; if (sp_out !== 8'hFC) begin n_fail++; $display("FAIL both_starts_sp got=%h exp=fc", sp_out); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_push_one();
        test_back_to_back();
        test_pull_two();
        test_wrap();
        test_count_zero();
        test_wait_states();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
